mc_control: RTL and testbench
=============================

Name: mc_control

Overview:
- Multicycle control unit for the RV32I core; sequences a shared-memory multicycle datapath (single memory port, IR/OldPC/Data/ALUOut registers).
- Replaces the single-cycle combinational controller. Sits beside the datapath and drives its enables and mux selects, one FSM state per cycle.
- Supports lw, sw, R-type (add/sub/and/or/slt), I-type ALU (addi/andi/ori/slti), beq and jal.

Parameters:
ILLEGAL_TRAP, 0, 0: unsupported opcode returns to FETCH (executes as NOP); 1: enter HALT until reset.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  asynchronous, active-high reset
opcode  input  7  instr[6:0] from IR
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
zero  input  1  ALU zero flag
pc_write  output  1  PC register enable
adr_src  output  1  memory address mux: 0 = PC, 1 = ALUOut
mem_write  output  1  memory write enable
ir_write  output  1  IR and OldPC enable
result_src  output  2  00 ALUOut, 01 Data, 10 ALUResult
alu_src_a  output  2  00 PC, 01 OldPC, 10 RD1
alu_src_b  output  2  00 RD2, 01 ImmExt, 10 constant 4
alu_control  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
imm_src  output  2  00 I, 01 S, 10 B, 11 J
reg_write  output  1  register file write enable
illegal  output  1  unsupported opcode seen in DECODE
state  output  4  current state, for debug

Behaviour:
- State register is the only storage. Reset asynchronously sets state to FETCH (0).
- All outputs except pc_write are Moore decodes of state. pc_write = pc_update | (branch & zero).
- While reset is high, pc_write, ir_write, mem_write and reg_write are forced to 0.
- Outputs not listed for a state are 0. Each line gives encoding, then outputs, then next state:
  - FETCH 0: adr_src 0, ir_write 1, a 00, b 10, aluop add, result_src 10, pc_update 1. Next: DECODE.
  - DECODE 1: a 01, b 01, aluop add (precomputes branch target). Next by opcode:
    - 0000011 or 0100011: MEMADR
    - 0110011: EXECUTER
    - 0010011: EXECUTEI
    - 1100011: BEQ
    - 1101111: JAL
    - anything else: illegal=1 for this cycle, then FETCH, or HALT if ILLEGAL_TRAP=1.
  - MEMADR 2: a 10, b 01, aluop add. Next: MEMREAD if opcode[5]=0, else MEMWRITE.
  - MEMREAD 3: adr_src 1, result_src 00. Next: MEMWB.
  - MEMWB 4: result_src 01, reg_write 1. Next: FETCH.
  - MEMWRITE 5: adr_src 1, mem_write 1. Next: FETCH.
  - EXECUTER 6: a 10, b 00, aluop funct. Next: ALUWB.
  - ALUWB 7: result_src 00, reg_write 1. Next: FETCH.
  - EXECUTEI 8: a 10, b 01, aluop funct. Next: ALUWB.
  - JAL 9: a 01, b 10, aluop add, result_src 00, pc_update 1. Next: ALUWB.
  - BEQ 10: a 10, b 00, aluop sub, result_src 00, branch 1. Next: FETCH.
  - HALT 11: all enables 0. Stays until reset.
  - Encodings 12-15: treated as FETCH next cycle, with all enables 0.
- ALU decode:
  - aluop add gives 000; aluop sub gives 001.
  - aluop funct by funct3:
    - 000: 001 if {opcode[5], funct7b5} == 11, else 000
    - 010: 101
    - 110: 011
    - 111: 010
    - other: 000
- imm_src is a combinational decode of opcode, valid in every state:
  - lw or I-type: 00
  - sw: 01
  - beq: 10
  - jal: 11
  - other: 00
- Cycles per instruction, FETCH to FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- beq with zero=0 leaves pc_write 0 in BEQ.
- Reset asserted mid-instruction aborts it. No write enable is asserted after reset rises. First post-reset edge performs FETCH.

Test Plan:
- Reset: assert reset mid-MEMWRITE -> state=0 immediately, mem_write=0; first cycle after deassert has ir_write=1, pc_write=1.
- lw (opcode 0000011) -> states 0,1,2,3,4,0; adr_src=1 in state 3; reg_write=1 with result_src=01 only in state 4.
- sub (0110011, funct3 000, funct7b5 1) -> alu_control=001 in state 6; with funct7b5=0 -> 000. addi with funct7b5=1 -> 000.
- beq with zero=1 -> pc_write=1 in state 10; zero=0 -> pc_write=0; 3 cycles total.
- jal -> states 0,1,9,7,0; pc_write=1 in state 9; imm_src=11 throughout.
- Opcode 0000000 -> illegal=1 in DECODE. ILLEGAL_TRAP=0: next state 0. ILLEGAL_TRAP=1: state 11 held with all enables 0 until reset.

Source files
------------

// File: rtl/mc_control.sv
// mc_control: multicycle control unit for the RV32I core.
// Sequences a shared-memory multicycle datapath one FSM state per clock, driving the
// enables and mux selects for the IR/OldPC/Data/ALUOut datapath.
//
// Parameters:
//   ILLEGAL_TRAP  0: unsupported opcode executes as a NOP; 1: enter HALT until reset
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous active-high reset
//   opcode       instr[6:0] from IR
//   funct3       instr[14:12]
//   funct7b5     instr[30]
//   zero         ALU zero flag
//   pc_write     PC register enable
//   adr_src      memory address mux (0 PC, 1 ALUOut)
//   mem_write    memory write enable
//   ir_write     IR and OldPC enable
//   result_src   result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   alu_src_a    ALU A mux (00 PC, 01 OldPC, 10 RD1)
//   alu_src_b    ALU B mux (00 RD2, 01 ImmExt, 10 constant 4)
//   alu_control  ALU operation (000 add, 001 sub, 010 and, 011 or, 101 slt)
//   imm_src      immediate format (00 I, 01 S, 10 B, 11 J)
//   reg_write    register file write enable
//   illegal      unsupported opcode seen in DECODE
//   state        current FSM state, for debug
module mc_control #(
    parameter bit ILLEGAL_TRAP = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_control,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StAluWb    = 4'd7,
        StExecuteI = 4'd8,
        StJal      = 4'd9,
        StBeq      = 4'd10,
        StHalt     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'd0,
        AluOpSub   = 2'd1,
        AluOpFunct = 2'd2
    } alu_op_t;

    localparam logic [6:0] OpLoad  = 7'b0000011;
    localparam logic [6:0] OpStore = 7'b0100011;
    localparam logic [6:0] OpRType = 7'b0110011;
    localparam logic [6:0] OpIType = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal   = 7'b1101111;

    state_t  state_q, state_d;
    alu_op_t alu_op;
    logic    pc_update, branch;
    logic    ir_write_s, mem_write_s, reg_write_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpRType:         state_d = StExecuteR;
                    OpIType:         state_d = StExecuteI;
                    OpBranch:        state_d = StBeq;
                    OpJal:           state_d = StJal;
                    default:         state_d = ILLEGAL_TRAP ? StHalt : StFetch;
                endcase
            end
            StMemAdr:   state_d = opcode[5] ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StExecuteR: state_d = StAluWb;
            StExecuteI: state_d = StAluWb;
            StJal:      state_d = StAluWb;
            StHalt:     state_d = StHalt;
            // MemWb, MemWrite, AluWb, Beq and unused encodings all return to fetch
            default:    state_d = StFetch;
        endcase
    end

    // Moore decode of the state register
    always_comb begin
        pc_update   = 1'b0;
        branch      = 1'b0;
        adr_src     = 1'b0;
        mem_write_s = 1'b0;
        ir_write_s  = 1'b0;
        reg_write_s = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = AluOpAdd;
        illegal     = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write_s = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                pc_update  = 1'b1;
            end
            StDecode: begin
                // OldPC + ImmExt: branch target ready in ALUOut for BEQ
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                illegal   = !(opcode inside {OpLoad, OpStore, OpRType, OpIType, OpBranch, OpJal});
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            StMemRead:  adr_src = 1'b1;
            StMemWb: begin
                result_src  = 2'b01;
                reg_write_s = 1'b1;
            end
            StMemWrite: begin
                adr_src     = 1'b1;
                mem_write_s = 1'b1;
            end
            StExecuteR: begin
                alu_src_a = 2'b10;
                alu_op    = AluOpFunct;
            end
            StAluWb:    reg_write_s = 1'b1;
            StExecuteI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = AluOpFunct;
            end
            StJal: begin
                // PC <= ALUOut (target from DECODE); OldPC + 4 forms the link value
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_update = 1'b1;
            end
            StBeq: begin
                alu_src_a = 2'b10;
                alu_op    = AluOpSub;
                branch    = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            AluOpSub:   alu_control = 3'b001;
            AluOpFunct: begin
                case (funct3)
                    // sub only for R-type; addi ignores instr[30]
                    3'b000:  alu_control = ({opcode[5], funct7b5} == 2'b11) ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
            default:    alu_control = 3'b000;
        endcase
    end

    always_comb begin
        case (opcode)
            OpStore:  imm_src = 2'b01;
            OpBranch: imm_src = 2'b10;
            OpJal:    imm_src = 2'b11;
            default:  imm_src = 2'b00;
        endcase
    end

    assign pc_write  = !reset && (pc_update || (branch && zero));
    assign ir_write  = !reset && ir_write_s;
    assign mem_write = !reset && mem_write_s;
    assign reg_write = !reset && reg_write_s;
    assign state     = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: drives two mc_control instances (ILLEGAL_TRAP 0 and 1) with a shared
// instruction stream and compares every cycle against a per-instruction micro-step
// schedule model.
module tb_mc_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;

    logic [1:0] pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src [2];
    logic [1:0] alu_src_a  [2];
    logic [1:0] alu_src_b  [2];
    logic [2:0] alu_control [2];
    logic [1:0] imm_src    [2];
    logic [3:0] state      [2];

    int checks   = 0;
    int failures = 0;
    bit halted1  = 1'b0;

    always #5 clk = ~clk;

    mc_control #(.ILLEGAL_TRAP(1'b0)) u_dut0 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write[0]), .adr_src(adr_src[0]), .mem_write(mem_write[0]),
        .ir_write(ir_write[0]), .result_src(result_src[0]), .alu_src_a(alu_src_a[0]),
        .alu_src_b(alu_src_b[0]), .alu_control(alu_control[0]), .imm_src(imm_src[0]),
        .reg_write(reg_write[0]), .illegal(illegal[0]), .state(state[0])
    );

    mc_control #(.ILLEGAL_TRAP(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .pc_write(pc_write[1]), .adr_src(adr_src[1]), .mem_write(mem_write[1]),
        .ir_write(ir_write[1]), .result_src(result_src[1]), .alu_src_a(alu_src_a[1]),
        .alu_src_b(alu_src_b[1]), .alu_control(alu_control[1]), .imm_src(imm_src[1]),
        .reg_write(reg_write[1]), .illegal(illegal[1]), .state(state[1])
    );

    typedef enum int {CLw, CSw, CR, CI, CBeq, CJal, CIll} cls_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, adr, mw, irw;
        logic [1:0] rs, sa, sb;
        logic [2:0] alu;
        logic       rw, ill;
    } ctl_t;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] op_of(cls_t c);
        case (c)
            CLw:     return 7'b0000011;
            CSw:     return 7'b0100011;
            CR:      return 7'b0110011;
            CI:      return 7'b0010011;
            CBeq:    return 7'b1100011;
            CJal:    return 7'b1101111;
            default: return 7'b0000000;
        endcase
    endfunction

    function automatic int n_cycles(cls_t c);
        case (c)
            CLw:     return 5;
            CSw, CR, CI, CJal: return 4;
            CBeq:    return 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [1:0] exp_imm(cls_t c);
        case (c)
            CSw:     return 2'b01;
            CBeq:    return 2'b10;
            CJal:    return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // ALU operation implied by the instruction mnemonic (add/sub/slt/or/and)
    function automatic logic [2:0] funct_alu(logic [2:0] f3, logic f7, bit is_r);
        case (f3)
            3'd0:    return (is_r && f7) ? 3'b001 : 3'b000;
            3'd2:    return 3'b101;
            3'd6:    return 3'b011;
            3'd7:    return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    // Expected controls on micro-step k of an instruction of class c
    function automatic ctl_t sched(cls_t c, int k, logic [2:0] f3, logic f7, logic z);
        ctl_t e = '0;
        if (k == 0) begin
            e.st = 4'd0; e.irw = 1; e.pcw = 1; e.sb = 2'b10; e.rs = 2'b10;
        end else if (k == 1) begin
            e.st = 4'd1; e.sa = 2'b01; e.sb = 2'b01; e.ill = (c == CIll);
        end else begin
            case (c)
                CLw: begin
                    if (k == 2) begin e.st = 4'd2; e.sa = 2'b10; e.sb = 2'b01; end
                    else if (k == 3) begin e.st = 4'd3; e.adr = 1; end
                    else begin e.st = 4'd4; e.rs = 2'b01; e.rw = 1; end
                end
                CSw: begin
                    if (k == 2) begin e.st = 4'd2; e.sa = 2'b10; e.sb = 2'b01; end
                    else begin e.st = 4'd5; e.adr = 1; e.mw = 1; end
                end
                CR: begin
                    if (k == 2) begin e.st = 4'd6; e.sa = 2'b10; e.alu = funct_alu(f3, f7, 1); end
                    else begin e.st = 4'd7; e.rw = 1; end
                end
                CI: begin
                    if (k == 2) begin
                        e.st = 4'd8; e.sa = 2'b10; e.sb = 2'b01; e.alu = funct_alu(f3, f7, 0);
                    end else begin e.st = 4'd7; e.rw = 1; end
                end
                CJal: begin
                    if (k == 2) begin e.st = 4'd9; e.sa = 2'b01; e.sb = 2'b10; e.pcw = 1; end
                    else begin e.st = 4'd7; e.rw = 1; end
                end
                CBeq: begin e.st = 4'd10; e.sa = 2'b10; e.alu = 3'b001; e.pcw = z; end
                default: ;
            endcase
        end
        return e;
    endfunction

    task automatic cmp_dut(input int d, input ctl_t e, input string where);
        string p;
        p = $sformatf("%s d%0d", where, d);
        check({p, " state"}, 32'(state[d]), 32'(e.st));
        check({p, " pc_write"}, 32'(pc_write[d]), 32'(e.pcw));
        check({p, " adr_src"}, 32'(adr_src[d]), 32'(e.adr));
        check({p, " mem_write"}, 32'(mem_write[d]), 32'(e.mw));
        check({p, " ir_write"}, 32'(ir_write[d]), 32'(e.irw));
        check({p, " result_src"}, 32'(result_src[d]), 32'(e.rs));
        check({p, " alu_src_a"}, 32'(alu_src_a[d]), 32'(e.sa));
        check({p, " alu_src_b"}, 32'(alu_src_b[d]), 32'(e.sb));
        check({p, " alu_control"}, 32'(alu_control[d]), 32'(e.alu));
        check({p, " reg_write"}, 32'(reg_write[d]), 32'(e.rw));
        check({p, " illegal"}, 32'(illegal[d]), 32'(e.ill));
    endtask

    // Runs one instruction from FETCH; entered and left at posedge+1.
    // zmode 0/1 forces zero, 2 randomizes it per cycle; stop_k < n aborts early.
    task automatic run_instr(input cls_t c, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input int zmode, input int stop_k);
        ctl_t e, halt_e;
        string where;
        halt_e = '0;
        halt_e.st = 4'd11;
        opcode   = op;
        funct3   = f3;
        funct7b5 = f7;
        for (int k = 0; k < n_cycles(c) && k < stop_k; k++) begin
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            where = $sformatf("%s op=%b k=%0d", c.name(), op, k);
            e = sched(c, k, f3, f7, zero);
            cmp_dut(0, e, where);
            cmp_dut(1, halted1 ? halt_e : e, where);
            check({where, " imm_src d0"}, 32'(imm_src[0]), 32'(exp_imm(c)));
            check({where, " imm_src d1"}, 32'(imm_src[1]), 32'(exp_imm(c)));
            @(posedge clk);
            #1;
        end
        if (c == CIll && stop_k >= 2) halted1 = 1'b1;
    endtask

    // Asserts reset away from an edge, checks immediate effect, releases at posedge+3
    task automatic do_reset();
        reset = 1'b1;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset async d%0d state", d), 32'(state[d]), 32'd0);
            check($sformatf("reset d%0d enables", d),
                  32'({pc_write[d], ir_write[d], mem_write[d], reg_write[d]}), 32'd0);
        end
        @(posedge clk);
        #3;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset held d%0d state", d), 32'(state[d]), 32'd0);
            check($sformatf("reset held d%0d enables", d),
                  32'({pc_write[d], ir_write[d], mem_write[d], reg_write[d]}), 32'd0);
        end
        reset   = 1'b0;
        halted1 = 1'b0;
    endtask

    function automatic logic [6:0] rand_illegal_op();
        logic [6:0] op;
        do op = 7'($urandom);
        while (op inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                          7'b1101111});
        return op;
    endfunction

    initial begin
        cls_t c;
        reset    = 1'b1;
        opcode   = '0;
        funct3   = '0;
        funct7b5 = 1'b0;
        zero     = 1'b0;
        #2;
        do_reset();

        run_instr(CLw, op_of(CLw), 3'd2, 1'b0, 2, 99);
        run_instr(CR, op_of(CR), 3'd0, 1'b1, 2, 99);        // sub
        run_instr(CR, op_of(CR), 3'd0, 1'b0, 2, 99);        // add
        run_instr(CI, op_of(CI), 3'd0, 1'b1, 2, 99);        // addi, instr[30] set
        run_instr(CR, op_of(CR), 3'd2, 1'b0, 2, 99);        // slt
        run_instr(CI, op_of(CI), 3'd6, 1'b0, 2, 99);        // ori
        run_instr(CR, op_of(CR), 3'd7, 1'b1, 2, 99);        // and
        run_instr(CBeq, op_of(CBeq), 3'd0, 1'b0, 1, 99);
        run_instr(CBeq, op_of(CBeq), 3'd0, 1'b0, 0, 99);
        run_instr(CJal, op_of(CJal), 3'd0, 1'b0, 2, 99);
        run_instr(CSw, op_of(CSw), 3'd2, 1'b0, 2, 99);

        // Abort a store while in MEMWRITE
        run_instr(CSw, op_of(CSw), 3'd2, 1'b0, 2, 3);
        check("pre-reset memwrite state", 32'(state[0]), 32'd5);
        check("pre-reset mem_write", 32'(mem_write[0]), 32'd1);
        #1;
        do_reset();
        run_instr(CLw, op_of(CLw), 3'd2, 1'b0, 2, 99);

        // Illegal opcode: dut0 resumes, dut1 halts until reset
        run_instr(CIll, 7'b0000000, 3'd0, 1'b0, 2, 99);
        run_instr(CLw, op_of(CLw), 3'd2, 1'b0, 2, 99);
        run_instr(CJal, op_of(CJal), 3'd0, 1'b0, 2, 99);
        #1;
        do_reset();

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 7) == 0) c = CIll;
            else c = cls_t'($urandom_range(0, 5));
            run_instr(c, (c == CIll) ? rand_illegal_op() : op_of(c), 3'($urandom),
                      1'($urandom), 2, 99);
            if ($urandom_range(0, 40) == 0) begin
                #1;
                do_reset();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
